render_shape_bank: RTL and testbench

- Parametrised successor to the single-shape rasteriser. Evaluates N_SHAPES rotated tangram pieces in parallel against the scan-order pixel stream.
- Each piece has its own incremental rotated-coordinate walker, stepped per pixel, line and frame.
- Piece parameters are double-buffered: shadow writes any time, committed on newframe.
- Returns the topmost covering piece index per pixel through a 2-stage pipeline feeding the VGA colour mux.

---
 rtl/render_shape_bank.sv | 229 ++++++++++++++++++++++
 tb/tb_render_shape_bank.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/render_shape_bank.sv
// render_shape_bank: evaluates N_SHAPES rotated tangram pieces in parallel
// against a scan-order pixel stream and reports the topmost covering piece.
// Each piece owns an incremental rotated-coordinate walker; piece parameters
// are double-buffered (shadow/committed) and committed at frame start.
// Optional feature: define RENDER_SHAPE_BANK_EDGE_EN to add the is_edge
// output, which flags pixels on the boundary of the winning piece.
module render_shape_bank #(
    parameter int N_SHAPES   = 7,
    parameter int FLOAT_BITS = 32,
    parameter int DCM_BITS   = 16,
    parameter int INT_BITS   = 16,
    parameter int ID_BITS    = (N_SHAPES > 1) ? $clog2(N_SHAPES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  newline,
    input  logic                  newframe,
    input  logic                  cfg_we,
    input  logic [ID_BITS-1:0]    cfg_idx,
    input  logic [1:0]            cfg_ty,
    input  logic [INT_BITS-1:0]   cfg_size,
    input  logic [FLOAT_BITS-1:0] cfg_sin,
    input  logic [FLOAT_BITS-1:0] cfg_cos,
    input  logic [FLOAT_BITS-1:0] cfg_ix,
    input  logic [FLOAT_BITS-1:0] cfg_iy,
`ifdef RENDER_SHAPE_BANK_EDGE_EN
    output logic                  is_edge,
`endif
    output logic                  out_valid,
    output logic                  hit,
    output logic [ID_BITS-1:0]    hit_id
);

    localparam logic [1:0] TY_TRI  = 2'd0;
    localparam logic [1:0] TY_SQR  = 2'd1;
    localparam logic [1:0] TY_PAR  = 2'd2;
    localparam logic [1:0] TY_DIS  = 2'd3;

    localparam logic signed [INT_BITS:0] ZERO = '0;
    localparam logic signed [INT_BITS:0] ONE  = (INT_BITS+1)'(1);

    typedef struct packed {
        logic [1:0]            ty;
        logic [INT_BITS-1:0]   size;
        logic [FLOAT_BITS-1:0] sin_s;
        logic [FLOAT_BITS-1:0] cos_s;
        logic [FLOAT_BITS-1:0] ix;
        logic [FLOAT_BITS-1:0] iy;
    } piece_t;

    localparam piece_t PIECE_RESET = '{ty: TY_DIS, default: '0};

    // Coverage test of one piece in its own integer coordinate frame.
    function automatic logic covers(
        input logic [1:0]            ty,
        input logic signed [INT_BITS:0] ox,
        input logic signed [INT_BITS:0] oy,
        input logic signed [INT_BITS:0] sum,
        input logic signed [INT_BITS:0] size
    );
        logic in_x, in_y, in_s;
        in_x = (ox >= ZERO) && (ox < size);
        in_y = (oy >= ZERO) && (oy < size);
        in_s = (sum >= ZERO) && (sum < size);
        case (ty)
            TY_TRI:  covers = (ox >= ZERO) && (oy >= ZERO) && (sum < size);
            TY_SQR:  covers = in_x && in_y;
            TY_PAR:  covers = in_y && in_s;
            default: covers = 1'b0;
        endcase
    endfunction

`ifdef RENDER_SHAPE_BANK_EDGE_EN
    // Boundary test; only meaningful when the same pixel is covered.
    function automatic logic on_boundary(
        input logic [1:0]            ty,
        input logic signed [INT_BITS:0] ox,
        input logic signed [INT_BITS:0] oy,
        input logic signed [INT_BITS:0] sum,
        input logic signed [INT_BITS:0] size
    );
        logic signed [INT_BITS:0] last;
        last = size - ONE;
        case (ty)
            TY_TRI:  on_boundary = (ox == ZERO) || (oy == ZERO) || (sum == last);
            TY_SQR:  on_boundary = (ox == ZERO) || (oy == ZERO) || (ox == last) || (oy == last);
            TY_PAR:  on_boundary = (oy == ZERO) || (oy == last) || (sum == ZERO) || (sum == last);
            default: on_boundary = 1'b0;
        endcase
    endfunction

    logic [N_SHAPES-1:0] bound_c;
    logic [N_SHAPES-1:0] bound_p1;
    logic                win_bound;
`endif

    piece_t              cfg_word;
    logic [N_SHAPES-1:0] cover_c;
    logic [N_SHAPES-1:0] cover_p1;
    logic                vld_p1;
    logic [ID_BITS-1:0]  win_id;

    assign cfg_word = '{ty: cfg_ty, size: cfg_size, sin_s: cfg_sin,
                        cos_s: cfg_cos, ix: cfg_ix, iy: cfg_iy};

    for (genvar g = 0; g < N_SHAPES; g++) begin : g_piece
        piece_t                         shadow;
        piece_t                         active;
        piece_t                         commit_val;
        logic                           wr_sel;
        logic signed [FLOAT_BITS-1:0]   x, y, rx, ry;
        logic signed [INT_BITS-1:0]     ox, oy;
        logic signed [INT_BITS:0]       ox_w, oy_w, sum, size_w;

        // A write landing on the commit edge goes straight through to the committed bank.
        assign wr_sel     = cfg_we && (cfg_idx == ID_BITS'(g));
        assign commit_val = wr_sel ? cfg_word : shadow;

        // Shadow entry: host writes at any time, independent of the stall.
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                shadow <= PIECE_RESET;
            else if (wr_sel)
                shadow <= cfg_word;
        end

        // Committed entry: refreshed from the shadow only at frame start.
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                active <= PIECE_RESET;
            else if (en && newframe)
                active <= commit_val;
        end

        // Rotated-coordinate walker: frame origin, row start, or one pixel step.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                x  <= '0;
                y  <= '0;
                rx <= '0;
                ry <= '0;
            end else if (en) begin
                if (newframe) begin
                    x  <= $signed(commit_val.ix);
                    y  <= $signed(commit_val.iy);
                    rx <= $signed(commit_val.ix) - $signed(commit_val.sin_s);
                    ry <= $signed(commit_val.iy) + $signed(commit_val.cos_s);
                end else if (newline) begin
                    x  <= rx;
                    y  <= ry;
                    rx <= rx - $signed(active.sin_s);
                    ry <= ry + $signed(active.cos_s);
                end else begin
                    x  <= x + $signed(active.cos_s);
                    y  <= y + $signed(active.sin_s);
                end
            end
        end

        // Integer part by arithmetic shift (floor), widened by one bit so the sum cannot wrap.
        assign ox     = INT_BITS'(x >>> DCM_BITS);
        assign oy     = INT_BITS'(y >>> DCM_BITS);
        assign ox_w   = (INT_BITS+1)'(ox);
        assign oy_w   = (INT_BITS+1)'(oy);
        assign sum    = ox_w + oy_w;
        assign size_w = $signed({1'b0, active.size});

        assign cover_c[g] = covers(active.ty, ox_w, oy_w, sum, size_w);
`ifdef RENDER_SHAPE_BANK_EDGE_EN
        assign bound_c[g] = on_boundary(active.ty, ox_w, oy_w, sum, size_w);
`endif
    end

    // ---- stage 1: per-piece coverage bits ----
    // Register coverage of the pixel currently held in the walkers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cover_p1 <= '0;
            vld_p1   <= 1'b0;
`ifdef RENDER_SHAPE_BANK_EDGE_EN
            bound_p1 <= '0;
`endif
        end else if (en) begin
            cover_p1 <= cover_c;
            vld_p1   <= 1'b1;
`ifdef RENDER_SHAPE_BANK_EDGE_EN
            bound_p1 <= bound_c;
`endif
        end
    end

    // Priority pick: the highest covering index is drawn on top.
    always_comb begin
        win_id = '0;
`ifdef RENDER_SHAPE_BANK_EDGE_EN
        win_bound = 1'b0;
`endif
        for (int i = 0; i < N_SHAPES; i++) begin
            if (cover_p1[i]) begin
                win_id = ID_BITS'(i);
`ifdef RENDER_SHAPE_BANK_EDGE_EN
                win_bound = bound_p1[i];
`endif
            end
        end
    end

    // ---- stage 2: merged hit / winner ----
    // Register the merged result toward the colour mux.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            hit       <= 1'b0;
            hit_id    <= '0;
`ifdef RENDER_SHAPE_BANK_EDGE_EN
            is_edge   <= 1'b0;
`endif
        end else if (en) begin
            out_valid <= vld_p1;
            hit       <= |cover_p1;
            hit_id    <= win_id;
`ifdef RENDER_SHAPE_BANK_EDGE_EN
            is_edge   <= win_bound;
`endif
        end
    end

endmodule

// File: tb/tb_render_shape_bank.sv
// Self-checking bench for render_shape_bank: directed scenarios plus random
// frames, all compared against a closed-form pixel model.
module tb_render_shape_bank;

    localparam int N = 7;

    logic        clk = 1'b0;
    logic        rst, en, newline, newframe, cfg_we;
    logic [2:0]  cfg_idx;
    logic [1:0]  cfg_ty;
    logic [15:0] cfg_size;
    logic [31:0] cfg_sin, cfg_cos, cfg_ix, cfg_iy;
    logic        out_valid, hit;
    logic [2:0]  hit_id;
`ifdef RENDER_SHAPE_BANK_EDGE_EN
    logic        is_edge;
`endif

    render_shape_bank #(.N_SHAPES(N)) dut (
        .clk(clk), .rst(rst), .en(en), .newline(newline), .newframe(newframe),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_ty(cfg_ty), .cfg_size(cfg_size),
        .cfg_sin(cfg_sin), .cfg_cos(cfg_cos), .cfg_ix(cfg_ix), .cfg_iy(cfg_iy),
`ifdef RENDER_SHAPE_BANK_EDGE_EN
        .is_edge(is_edge),
`endif
        .out_valid(out_valid), .hit(hit), .hit_id(hit_id)
    );

    always #5 clk = ~clk;

    typedef struct { int ty; int size; int sn; int cs; int ix; int iy; } cfg_t;

    cfg_t sh [N];
    cfg_t act [N];
    int   row, col;
    int   s1_v, s1_h, s1_id, s1_e;
    int   s2_v, s2_h, s2_id, s2_e;
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Pixel (row, col) of the frame: rotated position = origin + col*(cos,sin) + row*(-sin,cos).
    function automatic void eval(output int h, output int id, output int e);
        h = 0; id = 0; e = 0;
        for (int i = 0; i < N; i++) begin
            int x, y, ox, oy, s, sz, cov, bd;
            x  = act[i].ix + col * act[i].cs - row * act[i].sn;
            y  = act[i].iy + col * act[i].sn + row * act[i].cs;
            ox = x >>> 16;
            oy = y >>> 16;
            s  = ox + oy;
            sz = act[i].size;
            cov = 0; bd = 0;
            case (act[i].ty)
                0: begin
                    cov = (ox >= 0 && oy >= 0 && s < sz);
                    bd  = (ox == 0 || oy == 0 || s == sz - 1);
                end
                1: begin
                    cov = (ox >= 0 && ox < sz && oy >= 0 && oy < sz);
                    bd  = (ox == 0 || oy == 0 || ox == sz - 1 || oy == sz - 1);
                end
                2: begin
                    cov = (oy >= 0 && oy < sz && s >= 0 && s < sz);
                    bd  = (oy == 0 || oy == sz - 1 || s == 0 || s == sz - 1);
                end
                default: cov = 0;
            endcase
            if (cov != 0) begin
                h = 1; id = i; e = bd;
            end
        end
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            sh[i]  = '{3, 0, 0, 0, 0, 0};
            act[i] = '{3, 0, 0, 0, 0, 0};
        end
        row = 0; col = 0;
        s1_v = 0; s1_h = 0; s1_id = 0; s1_e = 0;
        s2_v = 0; s2_h = 0; s2_id = 0; s2_e = 0;
    endtask

    task automatic tick();
        int h, id, e;
        @(posedge clk);
        if (en) begin
            eval(h, id, e);
            s2_v = s1_v; s2_h = s1_h; s2_id = s1_id; s2_e = s1_e;
            s1_v = 1;    s1_h = h;    s1_id = id;    s1_e = e;
        end
        if (cfg_we && int'(cfg_idx) < N)
            sh[cfg_idx] = '{int'(cfg_ty), int'(cfg_size), int'(cfg_sin),
                            int'(cfg_cos), int'(cfg_ix), int'(cfg_iy)};
        if (en) begin
            if (newframe) begin
                for (int i = 0; i < N; i++) act[i] = sh[i];
                row = 0; col = 0;
            end else if (newline) begin
                row++; col = 0;
            end else begin
                col++;
            end
        end
        #1;
        chk("valid", int'(out_valid), s2_v);
        chk("hit", int'(hit), s2_h);
        chk("hit_id", int'(hit_id), s2_id);
`ifdef RENDER_SHAPE_BANK_EDGE_EN
        chk("edge", int'(is_edge), s2_h != 0 ? s2_e : 0);
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_hit", int'(hit), 0);
        chk("rst_id", int'(hit_id), 0);
        model_reset();
        #1;
        rst = 1'b0;
    endtask

    task automatic set_cfg(input int idx, input int ty, input int size,
                           input int sn, input int cs, input int ix, input int iy);
        cfg_idx  = 3'(idx);
        cfg_ty   = 2'(ty);
        cfg_size = 16'(size);
        cfg_sin  = sn;
        cfg_cos  = cs;
        cfg_ix   = ix;
        cfg_iy   = iy;
    endtask

    task automatic wr(input int idx, input int ty, input int size,
                      input int sn, input int cs, input int ix, input int iy);
        set_cfg(idx, ty, size, sn, cs, ix, iy);
        cfg_we = 1'b1;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic start_frame();
        en = 1'b1; newframe = 1'b1;
        tick();
        newframe = 1'b0;
    endtask

    task automatic start_line();
        en = 1'b1; newline = 1'b1;
        tick();
        newline = 1'b0;
    endtask

    function automatic int pick_step();
        case ($urandom % 4)
            0: return 32'h10000;
            1: return -32'h10000;
            2: return 0;
            default: return int'($urandom_range(0, 32'h20000)) - 32'h10000;
        endcase
    endfunction

    int exp_id [7] = '{2, 2, 5, 5, 5, 5, 0};
    int en_seq [6] = '{1, 0, 0, 1, 1, 1};

    initial begin
        en = 0; newline = 0; newframe = 0; cfg_we = 0;
        set_cfg(0, 0, 0, 0, 0, 0, 0);
        #2;
        do_reset();

        // Blank bank: nothing hits, out_valid rises on the second enabled edge.
        start_frame();
        chk("vld_lag1", int'(out_valid), 0);
        en = 1'b1;
        tick();
        chk("vld_lag2", int'(out_valid), 1);
        for (int k = 0; k < 18; k++) tick();

        // Triangle of size 10 along row 0.
        do_reset();
        en = 1'b0;
        wr(0, 0, 10, 0, 32'h10000, 0, 0);
        start_frame();
        for (int k = 1; k <= 13; k++) begin
            tick();
            if (k >= 2) begin
                chk("tri_hit", int'(hit), (k - 2) < 10 ? 1 : 0);
                chk("tri_id", int'(hit_id), 0);
            end
        end

        // Overlapping squares: higher index wins.
        do_reset();
        en = 1'b0;
        wr(2, 1, 4, 0, 32'h10000, 0, 0);
        wr(5, 1, 4, 0, 32'h10000, -32'h20000, 0);
        start_frame();
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k >= 2) chk("sq_id", int'(hit_id), exp_id[k - 2]);
        end

        // 90-degree rotated square over three rows.
        do_reset();
        en = 1'b0;
        wr(0, 1, 3, 32'h10000, 0, 32'h20000, 0);
        start_frame();
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 5; k++) tick();
            start_line();
        end
        for (int k = 0; k < 3; k++) tick();

        // Mid-frame shadow write, then a write coincident with newframe.
        do_reset();
        en = 1'b0;
        wr(0, 0, 10, 0, 32'h10000, 0, 0);
        start_frame();
        for (int k = 0; k < 3; k++) tick();
        wr(0, 0, 2, 0, 32'h10000, 0, 0);
        for (int k = 0; k < 8; k++) tick();
        start_frame();
        for (int k = 0; k < 6; k++) tick();
        set_cfg(0, 0, 5, 0, 32'h10000, 0, 0);
        cfg_we = 1'b1;
        start_frame();
        cfg_we = 1'b0;
        for (int k = 0; k < 8; k++) tick();

        // Stall mid-row, then asynchronous reset mid-row.
        do_reset();
        en = 1'b0;
        wr(0, 1, 8, 0, 32'h10000, 0, 0);
        start_frame();
        for (int k = 0; k < 6; k++) begin
            en = 1'(en_seq[k]);
            newline = (k == 1);
            tick();
        end
        newline = 1'b0;
        en = 1'b1;
        tick();
        do_reset();
        for (int k = 0; k < 6; k++) tick();

        // Random frames with random configuration and stalls.
        do_reset();
        for (int f = 0; f < 4; f++) begin
            for (int w = 0; w < 6; w++) begin
                en = 1'($urandom % 2);
                wr(int'($urandom % 8), int'($urandom % 4), int'($urandom_range(0, 12)),
                   pick_step(), pick_step(),
                   int'($urandom_range(0, 12 * 65536)) - 4 * 65536,
                   int'($urandom_range(0, 12 * 65536)) - 4 * 65536);
            end
            start_frame();
            for (int r = 0; r < 10; r++) begin
                int px;
                px = 0;
                while (px < 14) begin
                    en = 1'($urandom % 4 != 0);
                    if ($urandom % 16 == 0) begin
                        set_cfg(int'($urandom % 8), int'($urandom % 4), int'($urandom_range(0, 12)),
                                pick_step(), pick_step(), 0, 0);
                        cfg_we = 1'b1;
                    end
                    tick();
                    cfg_we = 1'b0;
                    if (en) px++;
                end
                start_line();
            end
        end
        en = 1'b1;
        for (int k = 0; k < 3; k++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
